// File: rtl/xbar_pkg.sv
// Shared crossbar constants and the port-index type used by the scheduler and its arbiters.
package xbar_pkg;

    localparam int unsigned NPORT = 16;
    localparam int unsigned SEL_W = 4;

    typedef logic [SEL_W-1:0] port_idx_t;

endpackage

// File: rtl/rr_arbiter_16.sv
// Per-output round-robin arbiter: registered one-hot grant, priority pointer advances past each winner.
module rr_arbiter_16
    import xbar_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NPORT-1:0] req,
    input  logic             ready,
    output logic [NPORT-1:0] gnt,
    output port_idx_t        ptr
);

    logic [NPORT-1:0]   r_gnt;
    port_idx_t          r_ptr;

    logic [NPORT-1:0]   w_low_mask;
    logic [2*NPORT-1:0] w_dbl;
    logic               w_found;
    port_idx_t          w_win;

    // Lower copy drops inputs below the pointer; the upper copy supplies the wrapped-around candidates.
    always_comb begin
        w_low_mask = ~((NPORT'(1) << r_ptr) - NPORT'(1));
        w_dbl      = {req, req} & {{NPORT{1'b1}}, w_low_mask};
        w_found    = 1'b0;
        w_win      = '0;
        for (int i = 2*NPORT-1; i >= 0; i--) begin
            if (w_dbl[i]) begin
                w_found = 1'b1;
                w_win   = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt <= '0;
            r_ptr <= '0;
        end else if (en && ready && w_found) begin
            r_gnt <= NPORT'(1) << w_win;
            r_ptr <= w_win + SEL_W'(1);
        end else begin
            r_gnt <= '0;
        end
    end

    assign gnt = r_gnt;
    assign ptr = r_ptr;

endmodule

// File: rtl/crossbar_rr_scheduler.sv
// 16x16 crossbar scheduler: decodes head-of-line requests per output and runs one round-robin arbiter per output.
module crossbar_rr_scheduler
    import xbar_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORT-1:0]       req_valid,
    input  logic [NPORT*SEL_W-1:0] req_sel,
    input  logic [NPORT-1:0]       out_ready,
    input  logic                   sched_en,
    output logic [NPORT-1:0]       grant0,
    output logic [NPORT-1:0]       grant1,
    output logic [NPORT-1:0]       grant2,
    output logic [NPORT-1:0]       grant3,
    output logic [NPORT-1:0]       grant4,
    output logic [NPORT-1:0]       grant5,
    output logic [NPORT-1:0]       grant6,
    output logic [NPORT-1:0]       grant7,
    output logic [NPORT-1:0]       grant8,
    output logic [NPORT-1:0]       grant9,
    output logic [NPORT-1:0]       grant10,
    output logic [NPORT-1:0]       grant11,
    output logic [NPORT-1:0]       grant12,
    output logic [NPORT-1:0]       grant13,
    output logic [NPORT-1:0]       grant14,
    output logic [NPORT-1:0]       grant15,
    output logic [NPORT-1:0]       grant_any,
    output logic [NPORT*SEL_W-1:0] rr_ptr
);

    logic [NPORT-1:0] w_req [NPORT];
    logic [NPORT-1:0] w_gnt [NPORT];
    port_idx_t        w_ptr [NPORT];

    for (genvar o = 0; o < NPORT; o++) begin : g_out
        // Each input targets exactly one output, so per-output arbitration alone yields a valid matching.
        for (genvar k = 0; k < NPORT; k++) begin : g_in
            assign w_req[o][k] = req_valid[k] && (req_sel[SEL_W*k +: SEL_W] == port_idx_t'(o));
        end

        rr_arbiter_16 u_arb (
            .clk   (clk),
            .rst   (rst),
            .en    (sched_en),
            .req   (w_req[o]),
            .ready (out_ready[o]),
            .gnt   (w_gnt[o]),
            .ptr   (w_ptr[o])
        );

        assign rr_ptr[SEL_W*o +: SEL_W] = w_ptr[o];
        assign grant_any[o]             = |w_gnt[o];
    end

    assign grant0  = w_gnt[0];
    assign grant1  = w_gnt[1];
    assign grant2  = w_gnt[2];
    assign grant3  = w_gnt[3];
    assign grant4  = w_gnt[4];
    assign grant5  = w_gnt[5];
    assign grant6  = w_gnt[6];
    assign grant7  = w_gnt[7];
    assign grant8  = w_gnt[8];
    assign grant9  = w_gnt[9];
    assign grant10 = w_gnt[10];
    assign grant11 = w_gnt[11];
    assign grant12 = w_gnt[12];
    assign grant13 = w_gnt[13];
    assign grant14 = w_gnt[14];
    assign grant15 = w_gnt[15];

endmodule

// File: tb/tb_crossbar_rr_scheduler.sv
// Scoreboard bench for crossbar_rr_scheduler: directed vectors push expectations, a monitor compares after each edge.
module tb_crossbar_rr_scheduler;

    logic        clk;
    logic        rst;
    logic [15:0] req_valid;
    logic [63:0] req_sel;
    logic [15:0] out_ready;
    logic        sched_en;
    logic [15:0] grant0, grant1, grant2, grant3, grant4, grant5, grant6, grant7;
    logic [15:0] grant8, grant9, grant10, grant11, grant12, grant13, grant14, grant15;
    logic [15:0] grant_any;
    logic [63:0] rr_ptr;

    crossbar_rr_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .out_ready (out_ready),
        .sched_en  (sched_en),
        .grant0    (grant0),
        .grant1    (grant1),
        .grant2    (grant2),
        .grant3    (grant3),
        .grant4    (grant4),
        .grant5    (grant5),
        .grant6    (grant6),
        .grant7    (grant7),
        .grant8    (grant8),
        .grant9    (grant9),
        .grant10   (grant10),
        .grant11   (grant11),
        .grant12   (grant12),
        .grant13   (grant13),
        .grant14   (grant14),
        .grant15   (grant15),
        .grant_any (grant_any),
        .rr_ptr    (rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [255:0] g;
        logic [15:0]  any;
        logic [63:0]  ptr;
    } exp_t;

    exp_t  q_exp[$];
    string q_name[$];

    int n_cmp  = 0;
    int n_miss = 0;

    logic [255:0] e_g;
    logic [63:0]  e_ptr;

    task automatic tick();
        @(negedge clk);
        e_g = '0;
    endtask

    task automatic clr_req();
        req_valid = '0;
        req_sel   = '0;
    endtask

    task automatic set_req(input int k, input int sel);
        req_valid[k]     = 1'b1;
        req_sel[4*k +: 4] = 4'(sel);
    endtask

    task automatic push(input string nm);
        exp_t e;
        e.g   = e_g;
        e.ptr = e_ptr;
        for (int o = 0; o < 16; o++) e.any[o] = |e_g[16*o +: 16];
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    task automatic set_full_load();
        clr_req();
        for (int k = 0; k < 16; k++) set_req(k, 15 - k);
    endtask

    task automatic exp_full_load();
        for (int o = 0; o < 16; o++) begin
            e_g[16*o +: 16]  = 16'h1 << (15 - o);
            e_ptr[4*o +: 4]  = 4'((16 - o) % 16);
        end
    endtask

    // Monitor: one expectation is consumed per clock, sampled just after the active edge.
    initial begin
        exp_t        e;
        string       nm;
        logic [255:0] act_g;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() != 0) begin
                e  = q_exp.pop_front();
                nm = q_name.pop_front();
                act_g = {grant15, grant14, grant13, grant12, grant11, grant10, grant9, grant8,
                         grant7, grant6, grant5, grant4, grant3, grant2, grant1, grant0};
                n_cmp++;
                if (act_g !== e.g) begin
                    n_miss++;
                    $display("FAIL %s grants: got %h expected %h", nm, act_g, e.g);
                end
                n_cmp++;
                if (grant_any !== e.any) begin
                    n_miss++;
                    $display("FAIL %s grant_any: got %h expected %h", nm, grant_any, e.any);
                end
                n_cmp++;
                if (rr_ptr !== e.ptr) begin
                    n_miss++;
                    $display("FAIL %s rr_ptr: got %h expected %h", nm, rr_ptr, e.ptr);
                end
            end
        end
    end

    initial begin
        logic [15:0] fair_g [4];
        logic [3:0]  fair_p [4];
        fair_g = '{16'h0004, 16'h0020, 16'h4000, 16'h0004};
        fair_p = '{4'd3, 4'd6, 4'd15, 4'd3};

        rst       = 1'b1;
        req_valid = '0;
        req_sel   = '0;
        out_ready = 16'hFFFF;
        sched_en  = 1'b1;
        e_g       = '0;
        e_ptr     = '0;

        // Reset with random traffic present
        for (int i = 0; i < 2; i++) begin
            tick();
            rst       = 1'b1;
            req_valid = 16'($urandom);
            req_sel   = {$urandom, $urandom};
            e_ptr     = '0;
            push("reset");
        end

        // Single request: input 3 -> output 9
        tick();
        rst = 1'b0;
        clr_req();
        set_req(3, 9);
        e_g[16*9 +: 16] = 16'h0008;
        e_ptr[4*9 +: 4] = 4'd4;
        push("single");

        tick();
        clr_req();
        push("single_one_cycle");

        // Fairness: inputs 2, 5, 14 continuously on output 0
        for (int i = 0; i < 4; i++) begin
            tick();
            clr_req();
            set_req(2, 0);
            set_req(5, 0);
            set_req(14, 0);
            e_g[0 +: 16] = fair_g[i];
            e_ptr[0 +: 4] = fair_p[i];
            push("fairness");
        end

        tick();
        clr_req();
        push("idle");

        // Wrap-around on output 7
        tick();
        set_req(14, 7);
        e_g[16*7 +: 16] = 16'h4000;
        e_ptr[4*7 +: 4] = 4'd15;
        push("wrap_setup");

        tick();
        clr_req();
        set_req(15, 7);
        set_req(0, 7);
        e_g[16*7 +: 16] = 16'h8000;
        e_ptr[4*7 +: 4] = 4'd0;
        push("wrap_15");

        tick();
        e_g[16*7 +: 16] = 16'h0001;
        e_ptr[4*7 +: 4] = 4'd1;
        push("wrap_0");

        // Blocking on output 4
        tick();
        clr_req();
        set_req(6, 4);
        e_g[16*4 +: 16] = 16'h0040;
        e_ptr[4*4 +: 4] = 4'd7;
        push("block_setup");

        for (int i = 0; i < 2; i++) begin
            tick();
            clr_req();
            set_req(1, 4);
            set_req(6, 4);
            out_ready = 16'hFFEF;
            push("block_hold");
        end

        tick();
        out_ready = 16'hFFFF;
        e_g[16*4 +: 16] = 16'h0002;
        e_ptr[4*4 +: 4] = 4'd2;
        push("block_release");

        // Full load, gating and mid-stream reset
        tick();
        set_full_load();
        exp_full_load();
        push("full_load");

        tick();
        sched_en = 1'b0;
        push("gated");

        tick();
        sched_en = 1'b1;
        exp_full_load();
        push("full_load_again");

        tick();
        rst   = 1'b1;
        e_ptr = '0;
        push("mid_reset");

        tick();
        rst = 1'b0;
        exp_full_load();
        push("full_after_reset");

        tick();
        clr_req();
        push("final_idle");

        for (int i = 0; i < 20 && q_exp.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        if (q_exp.size() != 0) begin
            n_cmp++;
            n_miss++;
            $display("FAIL drain: %0d expectations left, required 0", q_exp.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end

endmodule
